// File: rtl/psp_arb_pkg.sv
// Shared types and constants for the PSP memory-port arbiter.
package psp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } requester_t;

    localparam int ERR_TIMEOUT_BIT = 0;
    localparam int ERR_PROTO_BIT   = 1;

endpackage

// File: rtl/psp_arb_watchdog.sv
// Access watchdog: counts SERVE cycles without a memory response and raises
// a sticky timeout flag once the count saturates at TIMEOUT.
module psp_arb_watchdog #(
    parameter int TIMEOUT = 256,
    parameter int TO_W    = 9
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    input  logic run_i,
    input  logic resp_i,
    output logic timeout_o
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT);

    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (run_i && !resp_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + TO_W'(1);
        end
        timeout_d = timeout_q | (run_i && (cnt_d == LIMIT));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;

endmodule

// File: rtl/psp_mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter for the single PSP memory port.
// Define PSP_ARB_ROUND_ROBIN_EN to alternate grants on conflict; default is fixed D priority.
//
// state   | meaning
// IDLE    | no access in flight, requests arbitrated this cycle
// SERVE_I | fetch access on the memory port, waiting for m_resp
// SERVE_D | load/store access on the memory port, waiting for m_resp
module psp_mem_arbiter
    import psp_arb_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int TO_W    = 9
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] i_addr,
    input  logic        i_read,
    output logic [31:0] i_rdata,
    output logic        i_resp,
    input  logic [31:0] d_addr,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [3:0]  d_wmask,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_resp,
    output logic [31:0] m_addr,
    output logic        m_read,
    output logic        m_write,
    output logic [3:0]  m_wmask,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_resp,
    output logic        busy,
    output logic [1:0]  err
);

    arb_state_t  state_q, state_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic        m_read_q, m_read_d;
    logic        m_write_q, m_write_d;
    logic [3:0]  m_wmask_q, m_wmask_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic        err_proto_q, err_proto_d;
    logic        d_req;
    logic        d_first;
    logic        wd_clr;
    logic        wd_run;
    logic        timeout;

`ifdef PSP_ARB_ROUND_ROBIN_EN
    requester_t  rr_last_q, rr_last_d;
    assign d_first = (rr_last_q == REQ_I);
`else
    assign d_first = 1'b1;
`endif

    assign d_req = d_read | d_write;

    always_comb begin
        state_d     = state_q;
        m_addr_d    = m_addr_q;
        m_read_d    = m_read_q;
        m_write_d   = m_write_q;
        m_wmask_d   = m_wmask_q;
        m_wdata_d   = m_wdata_q;
        err_proto_d = err_proto_q;
`ifdef PSP_ARB_ROUND_ROBIN_EN
        rr_last_d   = rr_last_q;
`endif
        case (state_q)
            IDLE: begin
                if (d_read && d_write) begin
                    err_proto_d = 1'b1;
                end
                // A conflicting read+write is still honoured, as a write.
                if (d_req && (!i_read || d_first)) begin
                    state_d   = SERVE_D;
                    m_addr_d  = d_addr;
                    m_write_d = d_write;
                    m_read_d  = d_read & ~d_write;
                    m_wmask_d = d_wmask;
                    m_wdata_d = d_wdata;
`ifdef PSP_ARB_ROUND_ROBIN_EN
                    rr_last_d = REQ_D;
`endif
                end else if (i_read) begin
                    state_d   = SERVE_I;
                    m_addr_d  = i_addr;
                    m_read_d  = 1'b1;
                    m_write_d = 1'b0;
                    m_wmask_d = 4'h0;
                    m_wdata_d = 32'h0;
`ifdef PSP_ARB_ROUND_ROBIN_EN
                    rr_last_d = REQ_I;
`endif
                end
            end
            SERVE_I, SERVE_D: begin
                if (m_resp) begin
                    state_d   = IDLE;
                    m_read_d  = 1'b0;
                    m_write_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            m_addr_q    <= '0;
            m_read_q    <= 1'b0;
            m_write_q   <= 1'b0;
            m_wmask_q   <= '0;
            m_wdata_q   <= '0;
            err_proto_q <= 1'b0;
`ifdef PSP_ARB_ROUND_ROBIN_EN
            rr_last_q   <= REQ_I;
`endif
        end else begin
            state_q     <= state_d;
            m_addr_q    <= m_addr_d;
            m_read_q    <= m_read_d;
            m_write_q   <= m_write_d;
            m_wmask_q   <= m_wmask_d;
            m_wdata_q   <= m_wdata_d;
            err_proto_q <= err_proto_d;
`ifdef PSP_ARB_ROUND_ROBIN_EN
            rr_last_q   <= rr_last_d;
`endif
        end
    end

    assign wd_clr = (state_q == IDLE) && (state_d != IDLE);
    assign wd_run = (state_q != IDLE);

    psp_arb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr_i     (wd_clr),
        .run_i     (wd_run),
        .resp_i    (m_resp),
        .timeout_o (timeout)
    );

    assign m_addr  = m_addr_q;
    assign m_read  = m_read_q;
    assign m_write = m_write_q;
    assign m_wmask = m_wmask_q;
    assign m_wdata = m_wdata_q;

    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;
    assign i_resp  = (state_q == SERVE_I) && m_resp;
    assign d_resp  = (state_q == SERVE_D) && m_resp;
    assign busy    = (state_q != IDLE);

    assign err[ERR_TIMEOUT_BIT] = timeout;
    assign err[ERR_PROTO_BIT]   = err_proto_q;

endmodule

// File: tb/tb_psp_mem_arbiter.sv
// Scoreboard bench for psp_mem_arbiter: directed protocol cases plus randomized
// concurrent I/D traffic against a memory model and an abstract reference memory.
module tb_psp_mem_arbiter;

    localparam int TIMEOUT = 256;
    localparam int TO_W    = 9;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_read = 1'b0;
    logic [31:0] i_rdata;
    logic        i_resp;
    logic [31:0] d_addr = '0;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [3:0]  d_wmask = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_resp;
    logic [31:0] m_addr;
    logic        m_read;
    logic        m_write;
    logic [3:0]  m_wmask;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = '0;
    logic        m_resp = 1'b0;
    logic        busy;
    logic [1:0]  err;

    always #5 clk = ~clk;

    psp_mem_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wmask(d_wmask),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
        .m_addr(m_addr), .m_read(m_read), .m_write(m_write), .m_wmask(m_wmask),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_resp(m_resp),
        .busy(busy), .err(err)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        bit          rd;
        logic [31:0] data;
    } exp_t;

    exp_t iq[$];
    exp_t dq[$];

    bit [31:0] mem_m [bit [31:0]];
    bit [31:0] ref_m [bit [31:0]];
    bit        mem_auto = 1'b0;
    int        lat_cnt = 0;
    int        lat_tgt = 0;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] mask);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (mask[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: pops an expectation on every response pulse.
    always @(negedge clk) begin
        if (reset_n) begin
            if (i_resp && d_resp) chk("resp_both", {i_resp, d_resp}, 2'b00);
            if (i_resp) begin
                if (iq.size() == 0) chk("i_resp_unexpected", i_resp, 1'b0);
                else begin
                    exp_t e;
                    e = iq.pop_front();
                    chk("i_m_addr", m_addr, e.addr);
                    chk("i_m_read", m_read, 1'b1);
                    chk("i_rdata", i_rdata, e.data);
                end
            end
            if (d_resp) begin
                if (dq.size() == 0) chk("d_resp_unexpected", d_resp, 1'b0);
                else begin
                    exp_t e;
                    e = dq.pop_front();
                    chk("d_m_addr", m_addr, e.addr);
                    chk("d_m_write", m_write, !e.rd);
                    if (e.rd) chk("d_rdata", d_rdata, e.data);
                end
            end
        end
    end

    // Memory model with random 0..3 cycle response latency.
    initial forever begin
        @(posedge clk);
        #1;
        if (mem_auto) begin
            if (m_read || m_write) begin
                if (lat_cnt >= lat_tgt) begin
                    bit [31:0] cur;
                    cur = mem_m.exists(m_addr) ? mem_m[m_addr] : init_val(m_addr);
                    if (m_write) begin
                        mem_m[m_addr] = merge(cur, m_wdata, m_wmask);
                        m_rdata = $urandom;
                    end else begin
                        m_rdata = cur;
                    end
                    m_resp  = 1'b1;
                    lat_cnt = 0;
                    lat_tgt = $urandom_range(0, 3);
                end else begin
                    m_resp  = 1'b0;
                    m_rdata = $urandom;
                    lat_cnt++;
                end
            end else begin
                m_resp  = 1'b0;
                m_rdata = $urandom;
            end
        end
    end

    task automatic wait_resp(input bit is_i);
        int t;
        t = 0;
        while (1) begin
            @(negedge clk);
            if (is_i ? i_resp : d_resp) break;
            t++;
            if (t > 100) begin
                checks++;
                failures++;
                $display("FAIL %s_resp_timeout actual=none expected=resp", is_i ? "i" : "d");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; m_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_mrw", {m_read, m_write}, 2'b00);
        chk("rst_m_addr", m_addr, 32'h0);
        chk("rst_m_wmask", m_wmask, 4'h0);
        chk("rst_m_wdata", m_wdata, 32'h0);
        chk("rst_err", err, 2'b00);
    endtask

    // Called one step after the edge that entered SERVE; finishes the access.
    task automatic do_serve(input bit is_i, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] mask,
                            input int stall, input logic [31:0] rdata);
        if (is_i) iq.push_back('{addr, 1'b1, rdata});
        else      dq.push_back('{addr, !wr, rdata});
        chk("serve_busy", busy, 1'b1);
        chk("serve_addr", m_addr, addr);
        chk("serve_read", m_read, !wr);
        chk("serve_write", m_write, wr);
        if (wr) begin
            chk("serve_wdata", m_wdata, wdata);
            chk("serve_wmask", m_wmask, mask);
        end
        for (int s = 0; s < stall; s++) begin
            m_resp = 1'b0;
            tick();
            chk("stall_addr", m_addr, addr);
            chk("stall_wdata", m_wdata, wr ? wdata : 32'h0);
            chk("stall_wmask", m_wmask, wr ? mask : 4'h0);
            chk("stall_resp", {i_resp, d_resp}, 2'b00);
            chk("stall_busy", busy, 1'b1);
        end
        m_resp = 1'b1;
        m_rdata = rdata;
        #1;
        chk("resp_i", i_resp, is_i);
        chk("resp_d", d_resp, !is_i);
        tick();
        m_resp = 1'b0;
        if (is_i) i_read = 1'b0;
        else begin
            d_read = 1'b0;
            d_write = 1'b0;
        end
        chk("post_busy", busy, 1'b0);
        chk("post_mrw", {m_read, m_write}, 2'b00);
    endtask

    initial begin
        #500_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int first;
        do_reset();

        // I-only read with 1-cycle memory
        i_read = 1'b1; i_addr = 32'h0000_0040;
        #1;
        chk("lat_idle_mread", m_read, 1'b0);
        tick();
        do_serve(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 0, 32'hDEAD_BEEF);

        // first conflict: D before I in both builds
        i_read = 1'b1; i_addr = 32'h100;
        d_write = 1'b1; d_addr = 32'h200; d_wmask = 4'hF; d_wdata = 32'h1234_5678;
        tick();
        do_serve(1'b0, 1'b1, 32'h200, 32'h1234_5678, 4'hF, 0, 32'h0);
        tick();
        do_serve(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 0, 32'hCAFE_0100);

        // D-only write, then a second conflict
        d_write = 1'b1; d_addr = 32'h204; d_wmask = 4'h3; d_wdata = 32'h0BAD_F00D;
        tick();
        do_serve(1'b0, 1'b1, 32'h204, 32'h0BAD_F00D, 4'h3, 0, 32'h0);
        i_read = 1'b1; i_addr = 32'h104;
        d_read = 1'b1; d_addr = 32'h208;
        tick();
`ifdef PSP_ARB_ROUND_ROBIN_EN
        do_serve(1'b1, 1'b0, 32'h104, 32'h0, 4'h0, 0, 32'h1111_0104);
        tick();
        do_serve(1'b0, 1'b0, 32'h208, 32'h0, 4'h0, 0, 32'h55AA_0208);
`else
        do_serve(1'b0, 1'b0, 32'h208, 32'h0, 4'h0, 0, 32'h55AA_0208);
        tick();
        do_serve(1'b1, 1'b0, 32'h104, 32'h0, 4'h0, 0, 32'h1111_0104);
`endif

        // stalled store
        d_write = 1'b1; d_addr = 32'h2F0; d_wmask = 4'h5; d_wdata = 32'hA5A5_1234;
        tick();
        do_serve(1'b0, 1'b1, 32'h2F0, 32'hA5A5_1234, 4'h5, 3, 32'h0);
        chk("stall_err", err, 2'b00);

        // stray m_resp while idle
        m_resp = 1'b1;
        #1;
        chk("idle_resp", {i_resp, d_resp}, 2'b00);
        tick();
        m_resp = 1'b0;
        chk("idle_busy", busy, 1'b0);
        chk("idle_err", err, 2'b00);

        // read+write together
        d_read = 1'b1; d_write = 1'b1; d_addr = 32'h300; d_wmask = 4'hF; d_wdata = 32'h3030_3030;
        #1;
        chk("proto_err_before", err, 2'b00);
        tick();
        chk("proto_err", err, 2'b10);
        do_serve(1'b0, 1'b1, 32'h300, 32'h3030_3030, 4'hF, 0, 32'h0);
        chk("proto_err_sticky", err, 2'b10);
        do_reset();

        // watchdog
        d_read = 1'b1; d_addr = 32'h400;
        tick();
        chk("to_mread", m_read, 1'b1);
        first = -1;
        for (int k = 1; k <= TIMEOUT + 8; k++) begin
            tick();
            if (err[0] && first < 0) first = k;
        end
        chk("timeout_cycles", first, TIMEOUT);
        chk("timeout_busy", busy, 1'b1);
        dq.push_back('{32'h400, 1'b1, 32'h4040_4040});
        m_resp = 1'b1; m_rdata = 32'h4040_4040;
        #1;
        chk("late_d_resp", d_resp, 1'b1);
        tick();
        m_resp = 1'b0; d_read = 1'b0;
        chk("timeout_sticky", err, 2'b01);
        chk("late_busy", busy, 1'b0);
        do_reset();

        // reset in the middle of SERVE_I
        i_read = 1'b1; i_addr = 32'h80;
        tick();
        chk("mid_mread", m_read, 1'b1);
        #2;
        reset_n = 1'b0;
        m_resp = 1'b1;
        #1;
        chk("mid_rst_mread", m_read, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_iresp", i_resp, 1'b0);
        chk("mid_rst_err", err, 2'b00);
        i_read = 1'b0; m_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        i_read = 1'b1; i_addr = 32'h84;
        tick();
        do_serve(1'b1, 1'b0, 32'h84, 32'h0, 4'h0, 1, 32'h8484_8484);
        chk("directed_iq_empty", iq.size(), 0);
        chk("directed_dq_empty", dq.size(), 0);

        // randomized concurrent traffic
        lat_cnt = 0;
        lat_tgt = $urandom_range(0, 3);
        mem_auto = 1'b1;
        fork
            begin
                for (int n = 0; n < 60; n++) begin
                    logic [31:0] a;
                    repeat ($urandom_range(0, 3)) tick();
                    a = 32'h0000_0000 + 4 * $urandom_range(0, 255);
                    iq.push_back('{a, 1'b1, init_val(a)});
                    i_addr = a;
                    i_read = 1'b1;
                    wait_resp(1'b1);
                    i_read = 1'b0;
                end
            end
            begin
                for (int n = 0; n < 60; n++) begin
                    logic [31:0] a;
                    logic [31:0] cur;
                    repeat ($urandom_range(0, 3)) tick();
                    a = 32'h1000_0000 + 4 * $urandom_range(0, 15);
                    cur = ref_m.exists(a) ? ref_m[a] : init_val(a);
                    d_addr = a;
                    if ($urandom_range(0, 1) == 1) begin
                        d_wdata = $urandom;
                        d_wmask = 4'($urandom_range(0, 15));
                        ref_m[a] = merge(cur, d_wdata, d_wmask);
                        dq.push_back('{a, 1'b0, 32'h0});
                        d_write = 1'b1;
                    end else begin
                        dq.push_back('{a, 1'b1, cur});
                        d_read = 1'b1;
                    end
                    wait_resp(1'b0);
                    d_read = 1'b0;
                    d_write = 1'b0;
                end
            end
        join
        repeat (3) tick();
        mem_auto = 1'b0;
        chk("rand_iq_empty", iq.size(), 0);
        chk("rand_dq_empty", dq.size(), 0);
        chk("rand_err", err, 2'b00);
        chk("rand_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
